pdp_mem_arbiter: RTL and testbench
==================================

# pdp_mem_arbiter

Shares the single-port main memory between the instruction fetch unit (reads) and the execute unit (reads and writes). It arbitrates pending requests, sequences each access through a small state machine, and returns read data to the owning requester with a one-cycle valid pulse. Execute traffic has priority, and a starvation counter guarantees forward progress for fetch. It sits between `instr_decode`/`instr_exec` and the memory model in `top`.

## Interface
- ADDR_WIDTH, 12: memory address width.
- DATA_WIDTH, 12: memory word width.
- MEM_LATENCY, 1: cycles from `mem_en` (read) to valid `mem_rdata`; legal range 1..4.
- STARVE_LIMIT, 4: consecutive exec grants tolerated while fetch is pending; legal range 1..15.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  the only clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-high reset (asserted = 1).
- ifu_rd_req  in  1  fetch read request, level, held until `ifu_rd_gnt`.
- ifu_rd_addr  in  ADDR_WIDTH  fetch address, stable while `ifu_rd_req` is high.
- ifu_rd_gnt  out  1  one-cycle pulse: fetch request accepted.
- ifu_rd_valid  out  1  one-cycle pulse: `ifu_rd_data` valid.
- ifu_rd_data  out  DATA_WIDTH  fetch read data; holds its value until the next `ifu_rd_valid`.
- exec_rd_req, exec_wr_req  in  1 each  execute read/write requests, level, held until `exec_gnt`.
- exec_rd_addr, exec_wr_addr  in  ADDR_WIDTH  execute addresses.
- exec_wr_data  in  DATA_WIDTH  write data.
- exec_gnt  out  1  one-cycle pulse: the execute request (read or write) is accepted.
- exec_rd_valid  out  1  one-cycle pulse: `exec_rd_data` valid.
- exec_rd_data  out  DATA_WIDTH  execute read data; holds its value until the next `exec_rd_valid`.
- mem_en, mem_we  out  1 each  memory command; `mem_we=1` means write.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after a read `mem_en`.
- mem_busy  out  1  high whenever state != IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - WR: issue write.
  - RD: issue read.
  - WAIT: count down latency.
  - RESP: return data.
- Arbitration (IDLE only, requests sampled at the edge):
  - Priority order: exec_wr > exec_rd > ifu_rd.
  - Override: if `starve_cnt == STARVE_LIMIT` and `ifu_rd_req` is high, fetch wins.
- Transitions:
  - IDLE -> WR on a write win.
  - IDLE -> RD on a read win.
  - IDLE -> IDLE when no request is pending.
  - WR -> IDLE.
  - RD -> RESP if MEM_LATENCY = 1, else RD -> WAIT.
  - WAIT -> RESP after MEM_LATENCY-1 cycles.
  - RESP -> IDLE.
- In WR and RD, all outputs are registered:
  - `mem_en=1`.
  - `mem_we` = 1 in WR, 0 in RD.
  - `mem_addr` and `mem_wdata` are taken from the winner.
  - The winner's gnt is pulsed for exactly that cycle.
- Owner tag: records the read winner (IFU/EXEC) and routes the RESP data.
- RESP: captures `mem_rdata` into the owner's data register; the owner's valid pulses high in the same cycle.
- Requests are ignored outside IDLE. After its gnt, a requester deasserts or presents a new request. A request still high when the FSM next reaches IDLE is treated as a new request.
- starve_cnt (4 bits, saturating at STARVE_LIMIT):
  - Increments on each exec grant while `ifu_rd_req` is high.
  - Clears on an ifu grant, or in any IDLE cycle where `ifu_rd_req` is low.
- Outputs not being driven for an access are 0. `mem_addr`/`mem_wdata` are 0 when `mem_en` is 0.

## Timing
- Reset values:
  - All outputs 0, including both data registers.
  - state = IDLE, starve_cnt = 0, owner tag = IFU.
- Read: request sampled at edge T -> gnt and `mem_en` during cycle T+1 -> valid and data during cycle T+1+MEM_LATENCY.
  - With MEM_LATENCY = 1, valid is 2 cycles after the sampling edge.
  - A read occupies 2+MEM_LATENCY cycles including IDLE.
- Write: request sampled at T -> gnt plus write command during T+1 -> back in IDLE at T+2.
  - Peak throughput is one write per 2 cycles.
- Simultaneous `exec_wr_req` and `exec_rd_req`: the write goes first, then the read is granted on the next IDLE.
- Reset asserted mid-access (WR/RD/WAIT/RESP): return to IDLE next edge. No gnt or valid is produced. A late `mem_rdata` is discarded.
- No combinational path from any input to any output.

## Test plan
- Reset: hold reset_n=1 for 3 cycles with all reqs high -> every output is 0 and `mem_busy=0`. Release -> first grant is exec_wr.
- Fetch read, MEM_LATENCY=1: ifu_rd_addr=12'o0200 and memory[0200]=12'o7300.
  - `ifu_rd_gnt` and `mem_en` are high 1 cycle after sampling.
  - `ifu_rd_valid` is high with data 12'o7300 two cycles after sampling.
- Write then read: exec_wr (addr 12'o0050, data 12'o1234) and exec_rd (addr 12'o0050) asserted together.
  - The write is granted first.
  - The read then returns 12'o1234 on `exec_rd_valid`, and `ifu_rd_valid` stays 0.
- Starvation, STARVE_LIMIT=4: `ifu_rd_req` plus continuous exec reads -> exactly 4 exec grants, then an ifu grant, then starve_cnt = 0.
- Latency, MEM_LATENCY=3: exec_rd -> valid exactly 4 cycles after the gnt cycle begins its access, i.e. sampling edge + 4, with `mem_busy` high throughout.
- Reset mid-WAIT: assert reset during WAIT -> no valid pulse, and the data registers are 0. The next request is serviced normally.

Source files
------------

// File: rtl/pdp_mem_arbiter_if.sv
// Bundle of request, response and memory-command signals around the
// PDP main-memory arbiter. The slave modport is the arbiter's view: it
// serves the fetch/execute requesters and drives the memory command.
// The master modport is the environment's view: requesters plus memory.
interface pdp_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
) ();

    // fetch unit read port
    logic                  ifu_rd_req;
    logic [ADDR_WIDTH-1:0] ifu_rd_addr;
    logic                  ifu_rd_gnt;
    logic                  ifu_rd_valid;
    logic [DATA_WIDTH-1:0] ifu_rd_data;

    // execute unit read/write port
    logic                  exec_rd_req;
    logic                  exec_wr_req;
    logic [ADDR_WIDTH-1:0] exec_rd_addr;
    logic [ADDR_WIDTH-1:0] exec_wr_addr;
    logic [DATA_WIDTH-1:0] exec_wr_data;
    logic                  exec_gnt;
    logic                  exec_rd_valid;
    logic [DATA_WIDTH-1:0] exec_rd_data;

    // memory command / response
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_busy;

    modport slave (
        input  ifu_rd_req, ifu_rd_addr,
        output ifu_rd_gnt, ifu_rd_valid, ifu_rd_data,
        input  exec_rd_req, exec_wr_req, exec_rd_addr, exec_wr_addr, exec_wr_data,
        output exec_gnt, exec_rd_valid, exec_rd_data,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_busy,
        input  mem_rdata
    );

    modport master (
        output ifu_rd_req, ifu_rd_addr,
        input  ifu_rd_gnt, ifu_rd_valid, ifu_rd_data,
        output exec_rd_req, exec_wr_req, exec_rd_addr, exec_wr_addr, exec_wr_data,
        input  exec_gnt, exec_rd_valid, exec_rd_data,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_busy,
        output mem_rdata
    );

endinterface

// File: rtl/pdp_mem_arbiter.sv
// PDP main-memory arbiter: shares one single-port memory between the
// fetch unit (reads) and the execute unit (reads and writes). Execute
// wins by default; a starvation counter forces a fetch grant after
// STARVE_LIMIT consecutive execute grants while fetch is waiting.
// Every output is a flop or a decode of flops, so no input reaches an
// output combinationally.
module pdp_mem_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 12,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    pdp_mem_arbiter_if.slave    bus
);

    // FSM encoding
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] WR   = 3'd1;
    localparam logic [2:0] RD   = 3'd2;
    localparam logic [2:0] WAIT = 3'd3;
    localparam logic [2:0] RESP = 3'd4;

    // requester indices double as the owner tag values
    localparam int   NUM_REQ    = 2;
    localparam int   REQ_IFU    = 0;
    localparam int   REQ_EXEC   = 1;
    localparam logic OWNER_IFU  = 1'b0;
    localparam logic OWNER_EXEC = 1'b1;

    // WAIT lasts MEM_LATENCY-1 cycles; the counter is loaded with the
    // number of WAIT cycles left after the first one.
    localparam logic [1:0] WAIT_INIT  = (MEM_LATENCY > 1) ? 2'(MEM_LATENCY - 2) : 2'd0;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    // reset_n is active-high despite its name
    logic srst;
    assign srst = reset_n;

    logic [2:0]            state_reg;
    logic [2:0]            state_next;
    logic [1:0]            wait_cnt_reg;
    logic [3:0]            starve_cnt_reg;
    logic [3:0]            starve_cnt_next;
    logic                  owner_reg;

    logic                  grant_ifu;
    logic                  grant_exec_rd;
    logic                  grant_exec_wr;
    logic                  grant_any;
    logic                  starve_hit;
    logic                  resp_enter;

    logic                  mem_en_reg;
    logic                  mem_we_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_next;
    logic [DATA_WIDTH-1:0] mem_wdata_reg;
    logic [DATA_WIDTH-1:0] mem_wdata_next;
    logic                  ifu_gnt_reg;
    logic                  exec_gnt_reg;

    assign starve_hit = (starve_cnt_reg == STARVE_MAX) && bus.ifu_rd_req;
    assign grant_any  = grant_ifu | grant_exec_rd | grant_exec_wr;
    assign resp_enter = (state_next == RESP);

    // arbitration (IDLE only) and next-state decode
    always_comb begin
        grant_ifu     = 1'b0;
        grant_exec_rd = 1'b0;
        grant_exec_wr = 1'b0;
        state_next    = state_reg;
        case (state_reg)
            IDLE: begin
                if (starve_hit) begin
                    grant_ifu = 1'b1;
                end else if (bus.exec_wr_req) begin
                    grant_exec_wr = 1'b1;
                end else if (bus.exec_rd_req) begin
                    grant_exec_rd = 1'b1;
                end else if (bus.ifu_rd_req) begin
                    grant_ifu = 1'b1;
                end
                if (grant_exec_wr) begin
                    state_next = WR;
                end else if (grant_exec_rd || grant_ifu) begin
                    state_next = RD;
                end else begin
                    state_next = IDLE;
                end
            end
            WR:   state_next = IDLE;
            RD:   state_next = (MEM_LATENCY == 1) ? RESP : WAIT;
            WAIT: state_next = (wait_cnt_reg == 2'd0) ? RESP : WAIT;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // memory command fields of the winner; zero when nothing is issued
    always_comb begin
        mem_addr_next  = '0;
        mem_wdata_next = '0;
        if (grant_exec_wr) begin
            mem_addr_next  = bus.exec_wr_addr;
            mem_wdata_next = bus.exec_wr_data;
        end else if (grant_exec_rd) begin
            mem_addr_next  = bus.exec_rd_addr;
        end else if (grant_ifu) begin
            mem_addr_next  = bus.ifu_rd_addr;
        end
    end

    // starvation counter: counts exec grants while fetch waits
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (grant_ifu) begin
            starve_cnt_next = 4'd0;
        end else if ((state_reg == IDLE) && !bus.ifu_rd_req) begin
            starve_cnt_next = 4'd0;
        end else if ((grant_exec_rd || grant_exec_wr) && bus.ifu_rd_req &&
                     (starve_cnt_reg != STARVE_MAX)) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
        end
    end

    // state, counters and owner tag
    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg      <= IDLE;
            wait_cnt_reg   <= 2'd0;
            starve_cnt_reg <= 4'd0;
            owner_reg      <= OWNER_IFU;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            if (state_reg == RD) begin
                wait_cnt_reg <= WAIT_INIT;
            end else if ((state_reg == WAIT) && (wait_cnt_reg != 2'd0)) begin
                wait_cnt_reg <= wait_cnt_reg - 2'd1;
            end
            if (grant_ifu) begin
                owner_reg <= OWNER_IFU;
            end else if (grant_exec_rd) begin
                owner_reg <= OWNER_EXEC;
            end
        end
    end

    // registered memory command and grant pulses, live only in WR/RD
    always_ff @(posedge clk) begin
        if (srst) begin
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            ifu_gnt_reg   <= 1'b0;
            exec_gnt_reg  <= 1'b0;
        end else begin
            mem_en_reg    <= grant_any;
            mem_we_reg    <= grant_exec_wr;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            ifu_gnt_reg   <= grant_ifu;
            exec_gnt_reg  <= grant_exec_rd | grant_exec_wr;
        end
    end

    // per-requester response registers: data holds until the next valid
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            logic                  valid_reg;
            logic [DATA_WIDTH-1:0] data_reg;
            logic                  is_owner;

            assign is_owner = (owner_reg == 1'(gi));

            // capture memory data for this requester on entry to RESP
            always_ff @(posedge clk) begin
                if (srst) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else begin
                    valid_reg <= resp_enter && is_owner;
                    if (resp_enter && is_owner) begin
                        data_reg <= bus.mem_rdata;
                    end
                end
            end
        end
    endgenerate

    assign bus.ifu_rd_gnt    = ifu_gnt_reg;
    assign bus.ifu_rd_valid  = g_rsp[REQ_IFU].valid_reg;
    assign bus.ifu_rd_data   = g_rsp[REQ_IFU].data_reg;
    assign bus.exec_gnt      = exec_gnt_reg;
    assign bus.exec_rd_valid = g_rsp[REQ_EXEC].valid_reg;
    assign bus.exec_rd_data  = g_rsp[REQ_EXEC].data_reg;
    assign bus.mem_en        = mem_en_reg;
    assign bus.mem_we        = mem_we_reg;
    assign bus.mem_addr      = mem_addr_reg;
    assign bus.mem_wdata     = mem_wdata_reg;
    assign bus.mem_busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// Directed bench for pdp_mem_arbiter. Two instances: dut_a with
// MEM_LATENCY=1 and dut_b with MEM_LATENCY=3, each with its own memory
// model. Read results are predicted into per-port queues when the
// request is driven and popped when the matching valid pulse appears.
module tb_pdp_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    pdp_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
    pdp_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

    pdp_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1), .STARVE_LIMIT(4))
        dut_a (.clk(clk), .reset_n(rst), .bus(bus_a));
    pdp_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(3), .STARVE_LIMIT(4))
        dut_b (.clk(clk), .reset_n(rst), .bus(bus_b));

    // memory models: written words override a fixed preload pattern
    bit [DW-1:0] mem_a [0:(1<<AW)-1];
    bit          wr_a  [0:(1<<AW)-1];
    bit [DW-1:0] mem_b [0:(1<<AW)-1];
    bit          wr_b  [0:(1<<AW)-1];
    logic [DW-1:0] pipe_b1, pipe_b2;

    function automatic logic [DW-1:0] preload(input logic [AW-1:0] a);
        case (a)
            12'o0200: return 12'o7300;
            12'o0300: return 12'o4321;
            default:  return ~a;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus_a.mem_en && bus_a.mem_we) begin
            mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
            wr_a[bus_a.mem_addr]  <= 1'b1;
        end
    end
    // latency 1: data seen at the edge that ends the read command cycle
    assign bus_a.mem_rdata = (bus_a.mem_en && !bus_a.mem_we) ?
        (wr_a[bus_a.mem_addr] ? mem_a[bus_a.mem_addr] : preload(bus_a.mem_addr)) : 12'o5555;

    always @(posedge clk) begin
        if (bus_b.mem_en && bus_b.mem_we) begin
            mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
            wr_b[bus_b.mem_addr]  <= 1'b1;
        end
        pipe_b1 <= (bus_b.mem_en && !bus_b.mem_we) ?
            (wr_b[bus_b.mem_addr] ? mem_b[bus_b.mem_addr] : preload(bus_b.mem_addr)) : 12'o5555;
        pipe_b2 <= pipe_b1;
    end
    // latency 3: two pipeline stages after the command edge
    assign bus_b.mem_rdata = pipe_b2;

    logic [DW-1:0] q_a_ifu[$];
    logic [DW-1:0] q_a_exec[$];
    logic [DW-1:0] q_b_exec[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs_a();
        return 64'({bus_a.ifu_rd_gnt, bus_a.ifu_rd_valid, bus_a.ifu_rd_data,
                    bus_a.exec_gnt, bus_a.exec_rd_valid, bus_a.exec_rd_data,
                    bus_a.mem_en, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata,
                    bus_a.mem_busy});
    endfunction

    // scoreboard: compare every valid pulse against the predicted queue
    always @(negedge clk) begin
        if (bus_a.ifu_rd_valid === 1'b1) begin
            chk("a_ifu_valid_expected", 64'(q_a_ifu.size() > 0), 64'd1);
            if (q_a_ifu.size() > 0) chk("a_ifu_data", 64'(bus_a.ifu_rd_data), 64'(q_a_ifu.pop_front()));
            $display("[TB] dut_a fetch read data=%o", bus_a.ifu_rd_data);
        end
        if (bus_a.exec_rd_valid === 1'b1) begin
            chk("a_exec_valid_expected", 64'(q_a_exec.size() > 0), 64'd1);
            if (q_a_exec.size() > 0) chk("a_exec_data", 64'(bus_a.exec_rd_data), 64'(q_a_exec.pop_front()));
            $display("[TB] dut_a exec read data=%o", bus_a.exec_rd_data);
        end
        if (bus_b.exec_rd_valid === 1'b1) begin
            chk("b_exec_valid_expected", 64'(q_b_exec.size() > 0), 64'd1);
            if (q_b_exec.size() > 0) chk("b_exec_data", 64'(bus_b.exec_rd_data), 64'(q_b_exec.pop_front()));
            $display("[TB] dut_b exec read data=%o", bus_b.exec_rd_data);
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n_exec;
        bit  got_ifu;
        bit  saw_valid;
        int  n_lat;

        rst = 1'b1;
        bus_a.ifu_rd_req = 1'b0; bus_a.ifu_rd_addr = '0;
        bus_a.exec_rd_req = 1'b0; bus_a.exec_wr_req = 1'b0;
        bus_a.exec_rd_addr = '0; bus_a.exec_wr_addr = '0; bus_a.exec_wr_data = '0;
        bus_b.ifu_rd_req = 1'b0; bus_b.ifu_rd_addr = '0;
        bus_b.exec_rd_req = 1'b0; bus_b.exec_wr_req = 1'b0;
        bus_b.exec_rd_addr = '0; bus_b.exec_wr_addr = '0; bus_b.exec_wr_data = '0;

        // reset held with every request high
        bus_a.ifu_rd_req = 1'b1;  bus_a.ifu_rd_addr = 12'o0200;
        bus_a.exec_rd_req = 1'b1; bus_a.exec_rd_addr = 12'o0050;
        bus_a.exec_wr_req = 1'b1; bus_a.exec_wr_addr = 12'o0100; bus_a.exec_wr_data = 12'o0011;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("reset_outputs_%0d", i), outs_a(), 64'd0);
        end
        rst = 1'b0;
        tick();
        chk("first_gnt_exec_wr", 64'({bus_a.exec_gnt, bus_a.ifu_rd_gnt, bus_a.mem_en, bus_a.mem_we}), 64'(4'b1011));
        chk("first_wr_addr", 64'({bus_a.mem_addr, bus_a.mem_wdata}), 64'({12'o0100, 12'o0011}));
        bus_a.ifu_rd_req = 1'b0; bus_a.exec_rd_req = 1'b0; bus_a.exec_wr_req = 1'b0;
        tick();
        chk("idle_after_wr", 64'({bus_a.mem_busy, bus_a.mem_en, bus_a.mem_addr, bus_a.mem_wdata}), 64'd0);

        // fetch read, latency 1
        q_a_ifu.push_back(12'o7300);
        bus_a.ifu_rd_addr = 12'o0200; bus_a.ifu_rd_req = 1'b1;
        tick();
        chk("fetch_gnt", 64'({bus_a.ifu_rd_gnt, bus_a.exec_gnt, bus_a.mem_en, bus_a.mem_we}), 64'(4'b1010));
        chk("fetch_addr", 64'(bus_a.mem_addr), 64'(12'o0200));
        bus_a.ifu_rd_req = 1'b0;
        tick();
        chk("fetch_valid", 64'({bus_a.ifu_rd_valid, bus_a.ifu_rd_data}), 64'({1'b1, 12'o7300}));
        tick();
        chk("fetch_hold", 64'({bus_a.ifu_rd_valid, bus_a.ifu_rd_data, bus_a.mem_busy}), 64'({1'b0, 12'o7300, 1'b0}));

        // simultaneous write and read to the same word
        q_a_exec.push_back(12'o1234);
        bus_a.exec_wr_addr = 12'o0050; bus_a.exec_wr_data = 12'o1234; bus_a.exec_wr_req = 1'b1;
        bus_a.exec_rd_addr = 12'o0050; bus_a.exec_rd_req = 1'b1;
        tick();
        chk("wr_first", 64'({bus_a.exec_gnt, bus_a.mem_en, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata}),
            64'({1'b1, 1'b1, 1'b1, 12'o0050, 12'o1234}));
        bus_a.exec_wr_req = 1'b0;
        tick();
        chk("wr_done_idle", 64'({bus_a.exec_gnt, bus_a.mem_en, bus_a.mem_busy}), 64'd0);
        tick();
        chk("rd_second", 64'({bus_a.exec_gnt, bus_a.mem_en, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata}),
            64'({1'b1, 1'b1, 1'b0, 12'o0050, 12'o0000}));
        bus_a.exec_rd_req = 1'b0;
        tick();
        chk("wr_rd_valid", 64'({bus_a.exec_rd_valid, bus_a.exec_rd_data, bus_a.ifu_rd_valid}),
            64'({1'b1, 12'o1234, 1'b0}));
        tick();

        // starvation: continuous exec reads with fetch pending
        for (int i = 0; i < 4; i++) q_a_exec.push_back(12'o1234);
        q_a_ifu.push_back(12'o7300);
        bus_a.ifu_rd_req = 1'b1; bus_a.exec_rd_req = 1'b1;
        n_exec = 0; got_ifu = 1'b0;
        for (int c = 0; c < 60 && !got_ifu; c++) begin
            tick();
            if (bus_a.exec_gnt === 1'b1) begin
                n_exec++;
                if (n_exec == 4) chk("starve_cnt_at_limit", 64'(dut_a.starve_cnt_reg), 64'd4);
            end
            if (bus_a.ifu_rd_gnt === 1'b1) begin
                got_ifu = 1'b1;
                bus_a.ifu_rd_req = 1'b0; bus_a.exec_rd_req = 1'b0;
                chk("starve_cnt_clear", 64'(dut_a.starve_cnt_reg), 64'd0);
            end
        end
        chk("starve_ifu_gnt", 64'(got_ifu), 64'd1);
        chk("starve_exec_grants", 64'(n_exec), 64'd4);
        for (int i = 0; i < 4; i++) tick();

        // latency 3 on dut_b
        q_b_exec.push_back(12'o4321);
        bus_b.exec_rd_addr = 12'o0300; bus_b.exec_rd_req = 1'b1;
        tick();
        chk("b_gnt", 64'({bus_b.exec_gnt, bus_b.mem_en, bus_b.mem_we, bus_b.mem_addr}),
            64'({1'b1, 1'b1, 1'b0, 12'o0300}));
        bus_b.exec_rd_req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("b_lat_%0d", k), 64'({bus_b.mem_busy, bus_b.exec_rd_valid}), 64'({1'b1, k == 3}));
        end
        chk("b_lat_data", 64'(bus_b.exec_rd_data), 64'(12'o4321));
        tick();
        chk("b_idle", 64'(bus_b.mem_busy), 64'd0);

        // reset while dut_b is in WAIT
        bus_b.exec_rd_req = 1'b1;
        tick();
        bus_b.exec_rd_req = 1'b0;
        tick();
        chk("b_in_wait", 64'({bus_b.mem_busy, bus_b.mem_en}), 64'({1'b1, 1'b0}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("b_reset_mid_wait", 64'({bus_b.mem_busy, bus_b.exec_rd_valid, bus_b.exec_rd_data}), 64'd0);
        chk("a_data_cleared", 64'({bus_a.ifu_rd_data, bus_a.exec_rd_data}), 64'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            saw_valid = saw_valid | bus_b.exec_rd_valid | bus_b.exec_gnt;
        end
        chk("b_no_pulse_after_abort", 64'(saw_valid), 64'd0);

        // normal service after the aborted access
        q_b_exec.push_back(12'o4321);
        bus_b.exec_rd_req = 1'b1;
        tick();
        chk("b_regnt", 64'(bus_b.exec_gnt), 64'd1);
        bus_b.exec_rd_req = 1'b0;
        n_lat = 0;
        for (int c = 1; c <= 10 && n_lat == 0; c++) begin
            tick();
            if (bus_b.exec_rd_valid === 1'b1) n_lat = c;
        end
        chk("b_after_reset_latency", 64'(n_lat), 64'd3);
        chk("b_after_reset_data", 64'(bus_b.exec_rd_data), 64'(12'o4321));
        tick();
        tick();

        chk("a_ifu_queue_drained", 64'(q_a_ifu.size()), 64'd0);
        chk("a_exec_queue_drained", 64'(q_a_exec.size()), 64'd0);
        chk("b_exec_queue_drained", 64'(q_b_exec.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
